// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: feeds parallel words MSB-first into a serial 1011
// detector, counts its matches and ends a run on a match limit or stop.
module seq_detect_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] match_limit,
    input  logic             word_valid,
    input  logic [WIDTH-1:0] word_data,
    output logic             word_ready,
    output logic             det_clr,
    output logic             det_in,
    input  logic             det_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             underrun
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [BW-1:0]    bidx_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic [CNT_W-1:0] lim_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             und_q;
    logic             busy_q;
    logic             done_q;
    logic             det_clr_q;
    logic             accept;
    logic             limit_hit;

    // Match counter next value, saturating at all-ones, and limit detection.
    always_comb begin
        cnt_inc   = cnt_q + 1'b1;
        cnt_d     = cnt_q;
        if (det_out && (cnt_q != '1)) begin
            cnt_d = cnt_inc;
        end
        limit_hit = det_out && (lim_q != '0) && (cnt_inc == lim_q);
    end

    assign word_ready = busy_q && !hold_full_q;
    assign accept     = word_valid && word_ready;
    assign det_in     = (state_q == S_SHIFT) && sh_q[WIDTH-1];
    assign det_clr    = det_clr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign match_cnt  = cnt_q;
    assign underrun   = und_q;

    // Run sequencer: word intake, serialization, counting and run end.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            bidx_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            lim_q       <= '0;
            cnt_q       <= '0;
            und_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            det_clr_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                hold_q      <= word_data;
                hold_full_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_WAIT;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        und_q       <= 1'b0;
                        hold_full_q <= 1'b0;
                        lim_q       <= match_limit;
                    end
                end
                S_WAIT, S_SHIFT: begin
                    if (stop) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        det_clr_q   <= 1'b1;
                        hold_full_q <= 1'b0;
                    end else if (limit_hit) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        det_clr_q   <= 1'b1;
                        hold_full_q <= 1'b0;
                        cnt_q       <= lim_q;
                    end else begin
                        cnt_q <= cnt_d;
                        if (state_q == S_WAIT) begin
                            if (hold_full_q) begin
                                sh_q        <= hold_q;
                                bidx_q      <= LAST_IDX;
                                hold_full_q <= 1'b0;
                                state_q     <= S_SHIFT;
                                det_clr_q   <= 1'b0;
                            end
                        end else begin
                            sh_q   <= {sh_q[WIDTH-2:0], 1'b0};
                            bidx_q <= bidx_q - 1'b1;
                            if (bidx_q == '0) begin
                                if (hold_full_q) begin
                                    sh_q        <= hold_q;
                                    bidx_q      <= LAST_IDX;
                                    hold_full_q <= 1'b0;
                                end else begin
                                    state_q   <= S_WAIT;
                                    det_clr_q <= 1'b1;
                                    und_q     <= 1'b1;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: queue-based reference model of the controller plus
// a behavioural 1011 detector, directed scenarios and a random phase.
module tb_seq_detect_ctrl;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic          stop;
    logic [CW-1:0] match_limit;
    logic          word_valid;
    logic [W-1:0]  word_data;
    logic          word_ready;
    logic          det_clr;
    logic          det_in;
    logic          det_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] match_cnt;
    logic          underrun;

    logic [1:0]    lim2;
    logic          wr2, dc2, di2, do2, b2, dn2, un2;
    logic [1:0]    mc2;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    bit rec = 1'b0;
    bit shq[$];

    always #5 clk = ~clk;

    seq_detect_ctrl #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk(clk), .clr(clr), .start(start), .stop(stop),
        .match_limit(match_limit), .word_valid(word_valid),
        .word_data(word_data), .word_ready(word_ready),
        .det_clr(det_clr), .det_in(det_in), .det_out(det_out),
        .busy(busy), .done(done), .match_cnt(match_cnt),
        .underrun(underrun)
    );

    seq_detect_ctrl #(.WIDTH(W), .CNT_W(2)) u_dut2 (
        .clk(clk), .clr(clr), .start(start), .stop(stop),
        .match_limit(lim2), .word_valid(word_valid),
        .word_data(word_data), .word_ready(wr2),
        .det_clr(dc2), .det_in(di2), .det_out(do2),
        .busy(b2), .done(dn2), .match_cnt(mc2),
        .underrun(un2)
    );

    // Behavioural detectors: match flag one cycle after the final 1 of 1011.
    logic [3:0] dh, dh2;
    always_ff @(posedge clk or posedge clr) begin
        if (clr || det_clr) begin
            dh      <= '0;
            det_out <= 1'b0;
        end else begin
            dh      <= {dh[2:0], det_in};
            det_out <= ({dh[2:0], det_in} == 4'b1011);
        end
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr || dc2) begin
            dh2 <= '0;
            do2 <= 1'b0;
        end else begin
            dh2 <= {dh2[2:0], di2};
            do2 <= ({dh2[2:0], di2} == 4'b1011);
        end
    end

    // Reference model: run/finish flags, a queue of bits still to present
    // for the current word and a queue for the word waiting behind it.
    bit            m_run = 1'b0;
    bit            m_fin = 1'b0;
    bit            m_und = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    logic [CW-1:0] m_lim = '0;
    bit            m_bits[$];
    logic [W-1:0]  m_hold[$];

    function automatic void load(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) m_bits.push_back(w[i]);
    endfunction

    initial begin
        bit           hs;
        logic [W-1:0] hw;
        forever begin
            @(posedge clk or posedge clr);
            if (clr) begin
                m_run = 0; m_fin = 0; m_und = 0; m_cnt = '0; m_lim = '0;
                m_bits.delete(); m_hold.delete();
            end else if (m_fin) begin
                m_fin = 0;
            end else if (!m_run) begin
                if (start) begin
                    m_run = 1; m_cnt = '0; m_und = 0; m_lim = match_limit;
                    m_bits.delete(); m_hold.delete();
                end
            end else if (stop) begin
                m_run = 0;
                m_bits.delete(); m_hold.delete();
            end else if (det_out && m_lim != 0
                         && int'(m_cnt) + 1 == int'(m_lim)) begin
                m_cnt = m_lim; m_run = 0; m_fin = 1;
                m_bits.delete(); m_hold.delete();
            end else begin
                if (det_out && int'(m_cnt) < (1 << CW) - 1) m_cnt = m_cnt + 1;
                hs = (m_hold.size() == 0) && word_valid;
                hw = word_data;
                if (m_bits.size() > 0) begin
                    void'(m_bits.pop_front());
                    if (m_bits.size() == 0) begin
                        if (m_hold.size() > 0) load(m_hold.pop_front());
                        else m_und = 1;
                    end
                end else if (m_hold.size() > 0) begin
                    load(m_hold.pop_front());
                end
                if (hs) m_hold.push_back(hw);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic          e_busy, e_done, e_clr, e_in, e_rdy, e_und;
        logic [CW-1:0] e_cnt;
        forever begin
            @(negedge clk);
            e_busy = m_run;
            e_done = m_fin;
            e_clr  = !(m_run && m_bits.size() > 0);
            e_in   = (m_run && m_bits.size() > 0) ? m_bits[0] : 1'b0;
            e_rdy  = m_run && (m_hold.size() == 0);
            e_und  = m_und;
            e_cnt  = m_cnt;
            checks++;
            if (busy !== e_busy || done !== e_done || det_clr !== e_clr
                || det_in !== e_in || word_ready !== e_rdy
                || underrun !== e_und || match_cnt !== e_cnt) begin
                errors++;
                $display("FAIL cycle t=%0t got busy=%b done=%b clr=%b in=%b rdy=%b und=%b cnt=%0d want busy=%b done=%b clr=%b in=%b rdy=%b und=%b cnt=%0d",
                         $time, busy, done, det_clr, det_in, word_ready,
                         underrun, match_cnt, e_busy, e_done, e_clr, e_in,
                         e_rdy, e_und, e_cnt);
            end
            if (done === 1'b1) done_seen++;
            if (rec && det_clr === 1'b0) shq.push_back(det_in);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [CW-1:0] lim);
        match_limit = lim;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic put(input logic [W-1:0] w);
        int n = 0;
        word_valid = 1'b1;
        word_data  = w;
        while (word_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("put handshake in time", 32'(n < 200), 1);
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 100), 1);
    endtask

    task automatic wait_cnt(input string name, input logic [CW-1:0] v);
        int n = 0;
        while (match_cnt !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 200), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int d0;
        logic [3:0] v;
        clr = 1'b1; start = 1'b0; stop = 1'b0; word_valid = 1'b0;
        word_data = '0; match_limit = '0; lim2 = '0;
        cyc(2);
        chk("reset busy", 32'(busy), 0);
        chk("reset det_clr", 32'(det_clr), 1);
        chk("reset word_ready", 32'(word_ready), 0);
        chk("reset match_cnt", 32'(match_cnt), 0);
        chk("reset done", 32'(done), 0);
        chk("reset underrun", 32'(underrun), 0);
        chk("reset det_in", 32'(det_in), 0);
        clr = 1'b0;
        cyc(1);

        // Single word, limit 1.
        d0 = done_seen;
        shq.delete();
        rec = 1'b1;
        pulse_start(8'd1);
        put(8'hB0);
        wait_done("t1 done reached");
        cyc(2);
        rec = 1'b0;
        chk("t1 shift cycles", 32'(shq.size()), 5);
        v = (shq.size() >= 4) ? {shq[0], shq[1], shq[2], shq[3]} : 4'h0;
        chk("t1 first bits", 32'(v), 32'hB);
        chk("t1 match_cnt", 32'(match_cnt), 1);
        chk("t1 one done", 32'(done_seen - d0), 1);
        chk("t1 busy low", 32'(busy), 0);
        chk("t1 det_clr high", 32'(det_clr), 1);

        // Two gapless words, unlimited, then stop.
        d0 = done_seen;
        pulse_start(8'd0);
        put(8'hB0);
        put(8'hB0);
        chk("t2 ready low while held", 32'(word_ready), 0);
        wait_cnt("t2 two matches", 8'd2);
        chk("t2 still shifting", 32'(det_clr), 0);
        pulse_stop();
        cyc(1);
        chk("t2 match_cnt", 32'(match_cnt), 2);
        chk("t2 underrun", 32'(underrun), 0);
        chk("t2 idle", 32'(busy), 0);
        chk("t2 no done", 32'(done_seen - d0), 0);

        // Match across a word boundary, then the same with a gap.
        pulse_start(8'd0);
        put(8'h01);
        put(8'h60);
        cyc(20);
        chk("t3 boundary match", 32'(match_cnt), 1);
        pulse_stop();
        pulse_start(8'd0);
        put(8'h01);
        cyc(13);
        chk("t3 gap det_clr", 32'(det_clr), 1);
        chk("t3 gap underrun", 32'(underrun), 1);
        put(8'h60);
        cyc(12);
        chk("t3 gap no match", 32'(match_cnt), 0);
        pulse_stop();

        // Limit 2 over three words; start during DONE is ignored.
        pulse_start(8'd2);
        put(8'hB0);
        put(8'hB0);
        put(8'hB0);
        wait_done("t4 done reached");
        match_limit = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4 start in done ignored", 32'(busy), 0);
        cyc(2);
        chk("t4 match_cnt", 32'(match_cnt), 2);
        chk("t4 stays idle", 32'(busy), 0);

        // Asynchronous clear in the middle of a shift.
        pulse_start(8'd0);
        put(8'hB0);
        put(8'hB0);
        wait_cnt("t5 first match", 8'd1);
        @(posedge clk);
        #2 clr = 1'b1;
        #1;
        chk("t5 async busy", 32'(busy), 0);
        chk("t5 async det_clr", 32'(det_clr), 1);
        chk("t5 async word_ready", 32'(word_ready), 0);
        chk("t5 async match_cnt", 32'(match_cnt), 0);
        @(negedge clk);
        clr = 1'b0;
        cyc(1);
        pulse_start(8'd1);
        put(8'hB0);
        wait_done("t5 rerun done");
        cyc(1);
        chk("t5 rerun match_cnt", 32'(match_cnt), 1);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            clr         = ($urandom_range(0, 499) == 0);
            start       = ($urandom_range(0, 9) == 0);
            stop        = ($urandom_range(0, 79) == 0);
            match_limit = CW'($urandom_range(0, 3));
            word_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: word_data = 8'hB0;
                1: word_data = 8'h5B;
                2: word_data = 8'h6D;
                default: word_data = W'($urandom);
            endcase
        end
        @(negedge clk);
        clr = 1'b0; start = 1'b0; stop = 1'b0; word_valid = 1'b0;
        cyc(1);

        // Saturation of a 2-bit counter over five matching words.
        pulse_stop();
        cyc(2);
        pulse_start(8'd0);
        for (int k = 0; k < 5; k++) put(8'hB0);
        wait_cnt("t6 five matches", 8'd5);
        chk("t6 wide match_cnt", 32'(match_cnt), 5);
        chk("t6 narrow saturates", 32'(mc2), 3);
        chk("t6 narrow busy", 32'(b2), 1);
        pulse_stop();
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
